multi_mem_access_ctrl: RTL
==========================

// Module: multi_mem_access_ctrl
// PURPOSE
//  Load/store access controller between the multi-cycle CPU datapath and the
//  registered data memory wrapper (addr/we/re/din -> dout, READ_LAT cycles).
//  Accepts byte-addressed byte/half/word requests. Generates word address,
//  read/write enables and write data. Returns lane-extracted, sign/zero-extended
//  load data. Sub-word stores are done as read-modify-write.
// PARAMETERS
//  ADDR_W    10  memory word-address width; mem_addr = addr[ADDR_W+1:2]
//  READ_LAT  2   cycles from first mem_addr/mem_re cycle to valid mem_dout
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  req        in   1       request; sampled only in IDLE
//  we         in   1       1=store, 0=load
//  size       in   2       00=byte, 01=half, 10=word, 11=illegal (error)
//  uns        in   1       load zero-extend (1) / sign-extend (0)
//  addr       in   32      byte address, little-endian lanes
//  wdata      in   32      store data; low byte/half used for sub-word
//  rdata      out  32      load result, held until next load completes
//  done       out  1       one-cycle completion pulse
//  err        out  1       valid with done: misaligned or illegal access
//  busy       out  1       high in every state except IDLE
//  mem_addr   out  ADDR_W  word address to memory wrapper
//  mem_we     out  1       memory write enable
//  mem_re     out  1       memory read-capture enable
//  mem_din    out  32      memory write data
//  mem_dout   in   32      memory read data
// BEHAVIOUR
//  - Reset: state=IDLE; rdata, done, err, busy, mem_we, mem_re, mem_addr,
//    mem_din all 0. Reset mid-operation aborts at that edge with no done.
//    Memory outputs are state-decoded, so a write already in a WR cycle at
//    the reset edge still completes.
//  - FSM: IDLE -> RD -> (WR) -> DONE -> IDLE; IDLE -> ERR -> IDLE.
//  - IDLE: req=1 latches we/size/uns/addr/wdata at edge k.
//    Misaligned request (half with addr[0]=1, word with addr[1:0]!=0, or
//    size=11) -> ERR: one cycle with done=1, err=1, no memory access.
//  - RD: READ_LAT+1 cycles, mem_addr held, mem_re=1, mem_we=0, 3-bit counter.
//    At the last RD edge, mem_dout is captured. Load -> rdata, then DONE.
//    Sub-word store -> merge register, then WR.
//  - Word store skips RD: IDLE -> WR directly.
//  - WR: exactly one cycle with mem_we=1, mem_re=0. mem_din = wdata (word) or
//    the captured word with the lane at addr[1:0] replaced (byte lane
//    8*addr[1:0]; half lane 16*addr[1]).
//  - DONE: done=1 for one cycle, err=0, busy=1; then IDLE.
//    A req held high is accepted again on the first IDLE edge.
//  - Latency from accept edge k: load done in cycle after k+READ_LAT+1;
//    word store after k+1; sub-word store after k+READ_LAT+2; error after k.
//  - Load extract: byte = mem_dout[8*a+:8], half = mem_dout[16*a[1]+:16],
//    with a = addr[1:0]. Extend to 32 bits per uns.
//  - Address bits above ADDR_W+1 are ignored (wrap modulo memory size).
//  - req, we, addr and data changes while busy are ignored.
// CONFIGURATION
//  SUBWORD_RMW_EN defined: sub-word stores use RD+WR read-modify-write as
//    described above.
//  Not defined: byte/half stores are rejected via ERR (done=1, err=1) with
//    no memory access. Loads of all sizes and word stores are unchanged.
// TESTING
//  1 word store addr=0x10, wdata=0xDEADBEEF -> one mem_we cycle, mem_addr=4;
//    done 2 cycles after accept, err=0.
//  2 word load addr=0x10 -> mem_re for 3 cycles; rdata=0xDEADBEEF, done 4
//    cycles after accept.
//  3 byte load addr=0x13 signed -> rdata=0xFFFFFFDE; unsigned -> 0x000000DE;
//    half load addr=0x12 signed -> 0xFFFFDEAD.
//  4 byte store addr=0x11, wdata=0x55 (RMW_EN) -> mem_din=0xDEAD55EF, then
//    word load returns 0xDEAD55EF. Without macro -> err=1, memory unchanged.
//  5 half load addr=0x11 / word load addr=0x12 / size=11 -> done=err=1 in
//    cycle after accept; mem_re=mem_we=0 throughout.
//  6 rst asserted during RD of a load -> IDLE next cycle, no done, rdata keeps
//    its prior value; req held high during DONE -> accepted the next edge.

Source files
------------

// File: rtl/multi_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// multi_mem_access_ctrl
//
// Load/store access controller sitting between the multi-cycle CPU datapath
// and the registered data memory wrapper. Takes byte-addressed byte, half and
// word requests, drives the word-addressed memory port, and returns
// lane-extracted, sign- or zero-extended load data. Sub-word stores are done
// as a read-modify-write when SUBWORD_RMW_EN is defined. Without that macro,
// byte and half stores are rejected through the error path with no memory
// access.
//
// Configuration macro: SUBWORD_RMW_EN
//
// Parameters
//   ADDR_W    memory word-address width (mem_addr = addr[ADDR_W+1:2])
//   READ_LAT  cycles from the first mem_re cycle to valid mem_dout
//
// Ports
//   clk       in   1       system clock, rising edge
//   rst       in   1       synchronous active-high reset
//   req       in   1       request, sampled only while idle
//   we        in   1       1 = store, 0 = load
//   size      in   2       00 byte, 01 half, 10 word, 11 illegal
//   uns       in   1       load zero-extend (1) / sign-extend (0)
//   addr      in   32      byte address, little-endian lanes
//   wdata     in   32      store data (low byte/half used for sub-word)
//   rdata     out  32      load result, held until the next load completes
//   done      out  1       one-cycle completion pulse
//   err       out  1       valid with done: misaligned or illegal access
//   busy      out  1       high whenever not idle
//   mem_addr  out  ADDR_W  word address to the memory wrapper
//   mem_we    out  1       memory write enable
//   mem_re    out  1       memory read-capture enable
//   mem_din   out  32      memory write data
//   mem_dout  in   32      memory read data
// ---------------------------------------------------------------------------
module multi_mem_access_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    // The read phase lasts READ_LAT+1 cycles; the capture happens when the
    // counter reaches this value.
    localparam logic [2:0] RD_LAST = 3'(READ_LAT);

    logic [2:0]        state;
    logic [2:0]        cnt;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] waddr_q;
    // Holds the word to be written: raw wdata for word stores, the merged
    // word after the read phase of a sub-word store.
    logic [31:0]       word_q;

    logic              misaligned;
    logic              reject;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_ext;

    // Address bits above the memory size are deliberately dropped so that
    // accesses wrap modulo the memory.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    // Request classification, evaluated on the live inputs while idle.
    always_comb begin
        misaligned = (size == 2'b11)
                   | ((size == 2'b01) & addr[0])
                   | ((size == 2'b10) & (addr[1:0] != 2'b00));
`ifdef SUBWORD_RMW_EN
        reject = misaligned;
`else
        reject = misaligned | (we & (size != 2'b10));
`endif
    end

    // Lane extraction and sign/zero extension of the captured read word.
    always_comb begin
        byte_sel = mem_dout[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? mem_dout[31:16] : mem_dout[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_ext = mem_dout;
        endcase
    end

`ifdef SUBWORD_RMW_EN
    logic [31:0] merge_word;

    // Replace the addressed lane of the read word with the store data.
    always_comb begin
        merge_word = mem_dout;
        if (size_q == 2'b00) begin
            merge_word[{lane_q, 3'b000} +: 8] = word_q[7:0];
        end else begin
            merge_word[{lane_q[1], 4'b0000} +: 16] = word_q[15:0];
        end
    end
`endif

    // Main controller FSM. Request fields are latched only on acceptance,
    // so anything driven while busy is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            rdata   <= 32'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            lane_q  <= 2'b00;
            waddr_q <= '0;
            word_q  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        uns_q   <= uns;
                        lane_q  <= addr[1:0];
                        waddr_q <= addr[ADDR_W+1:2];
                        word_q  <= wdata;
                        cnt     <= 3'd0;
                        if (reject) begin
                            state <= S_ERR;
                        end else if (we && (size == 2'b10)) begin
                            state <= S_WR;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (cnt == RD_LAST) begin
                        if (we_q) begin
`ifdef SUBWORD_RMW_EN
                            word_q <= merge_word;
`endif
                            state <= S_WR;
                        end else begin
                            rdata <= load_ext;
                            state <= S_DONE;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_WR:    state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status and memory port are decoded from the state, so a write that is
    // in its WR cycle at a reset edge still lands in memory.
    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE) || (state == S_ERR);
        err      = (state == S_ERR);
        mem_re   = (state == S_RD);
        mem_we   = (state == S_WR);
        mem_addr = (mem_re || mem_we) ? waddr_q : '0;
        mem_din  = mem_we ? word_q : 32'd0;
    end

endmodule
